// File: rtl/irom_loader_pkg.sv
// Shared types and constants for the instruction RAM loader: FSM state
// encoding, default geometry and the filler instruction.
package irom_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } ld_state_e;

  localparam int          DEF_DEPTH_WORDS = 4096;
  localparam int          IDX_W           = $clog2(DEF_DEPTH_WORDS);
  localparam logic [31:0] DEF_NOP_INST    = 32'h0000_0013;

endpackage

// File: rtl/irom_ram.sv
// Word-organised instruction RAM: asynchronous read, synchronous write.
// Kept separate so a vendor macro can replace the inferred array.
module irom_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/irom_loader.sv
// Fetch-side instruction responder with a byte-serial program loader that
// holds the core in reset until a length-prefixed image has been written.
module irom_loader
  import irom_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          BOOT_WAIT   = 1'b1,
  parameter logic [31:0] NOP_INST    = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        ld_start_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  output logic        ld_ready_o,
  output logic        core_rstn_o,
  output logic        load_done_o,
  output logic        err_o,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a load byte transfers on a rising clk edge where
  // ld_valid_i and ld_ready_o are both high; ld_ready_o never depends on
  // ld_valid_i, and bytes offered while ld_ready_o is low are discarded.

  ld_state_e   state;
  logic [1:0]  byte_cnt;
  logic [AW-1:0] wcnt;
  logic [31:0] len;
  logic [23:0] asm_q;

  logic        accept;
  logic        word_last;
  logic        start_load;
  logic        last_word;
  logic [31:0] len_full;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] rd_off;
  logic        rd_in_range;
  logic [31:0] ram_rdata;

  assign accept     = ld_valid_i & ld_ready_o;
  assign word_last  = (byte_cnt == 2'd3);
  assign start_load = ld_start_i & ((state == IDLE) | (state == DONE));
  assign len_full   = {ld_data_i, len[23:0]};
  assign last_word  = (32'(wcnt) == (len - 32'd1));
  assign ram_we     = accept & (state == DATA) & word_last;
  assign ram_wdata  = {ld_data_i, asm_q};
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ld_ready_o  <= 1'b0;
      load_done_o <= 1'b0;
      err_o       <= 1'b0;
      core_rstn_o <= ~BOOT_WAIT;
      byte_cnt    <= 2'd0;
      wcnt        <= '0;
      len         <= 32'd0;
      asm_q       <= 24'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Release lags DONE entry by one cycle so RAM writes settle first.
          if (state == DONE) core_rstn_o <= 1'b1;
          if (start_load) begin
            state       <= LEN;
            ld_ready_o  <= 1'b1;
            core_rstn_o <= 1'b0;
            load_done_o <= 1'b0;
            err_o       <= 1'b0;
            byte_cnt    <= 2'd0;
            wcnt        <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            len[8*byte_cnt +: 8] <= ld_data_i;
            if (word_last) begin
              if (len_full == 32'd0) begin
                state       <= DONE;
                ld_ready_o  <= 1'b0;
                load_done_o <= 1'b1;
              end else if (len_full > 32'(DEPTH_WORDS)) begin
                state      <= IDLE;
                ld_ready_o <= 1'b0;
                err_o      <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    asm_q[7:0]   <= ld_data_i;
              2'd1:    asm_q[15:8]  <= ld_data_i;
              2'd2:    asm_q[23:16] <= ld_data_i;
              default: ;
            endcase
            if (word_last) begin
              wcnt <= wcnt + 1'b1;
              if (last_word) begin
                state       <= DONE;
                ld_ready_o  <= 1'b0;
                load_done_o <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  irom_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wcnt),
    .wdata (ram_wdata),
    .raddr (rd_off[AW+1:2]),
    .rdata (ram_rdata)
  );

  assign rd_off      = inst_addr_i - BASE_ADDR;
  assign rd_in_range = (inst_addr_i >= BASE_ADDR) && ((rd_off >> 2) < 32'(DEPTH_WORDS));
  assign inst_o      = (rd_in_range && ((state == IDLE) || (state == DONE))) ? ram_rdata : NOP_INST;

endmodule

// File: tb/tb_irom_loader.sv
// Bench for irom_loader: streams length-prefixed images and compares fetches
// against a word map built from the byte stream.
module tb_irom_loader;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic [31:0] inst_o;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'd0;
  logic        ld_ready_o;
  logic        core_rstn_o;
  logic        load_done_o;
  logic        err_o;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_mem [int];  // words known to be in RAM
  logic [7:0]  bq [$];         // byte stream of the current load

  irom_loader dut (
    .clk         (clk),
    .rstn        (rstn),
    .inst_addr_i (inst_addr),
    .inst_o      (inst_o),
    .ld_start_i  (ld_start),
    .ld_valid_i  (ld_valid),
    .ld_data_i   (ld_data),
    .ld_ready_o  (ld_ready_o),
    .core_rstn_o (core_rstn_o),
    .load_done_o (load_done_o),
    .err_o       (err_o),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks (entered and left at posedge + 1) -------
  task automatic start_pulse();
    @(negedge clk); ld_start = 1'b1;
    @(posedge clk); #1; ld_start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    ld_valid = 1'b1; ld_data = b;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (ld_ready_o) begin
        @(posedge clk); #1; ok = 1;
      end
    end
    ld_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL byte_accept: byte %02h not accepted, ready=%b required=1", b, ld_ready_o);
      @(posedge clk); #1;
    end
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic stream(input int gap_max, input int limit);
    for (int i = 0; i < bq.size() && i < limit; i++)
      drive_byte(bq[i], (i == bq.size() - 1) ? 0 : $urandom_range(0, gap_max));
  endtask

  task automatic drive_ignored(input int cycles);
    ld_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      ld_data = 8'($urandom);
      @(negedge clk);
      total++;
      if (ld_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL ignored_ready: ld_ready_o=%b required=0", ld_ready_o);
      end
    end
    ld_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  task automatic build_load(input int nwords);
    logic [31:0] n = 32'(nwords);
    bq.delete();
    for (int k = 0; k < 4; k++) bq.push_back(n[8*k +: 8]);
    for (int i = 0; i < 4 * nwords; i++) bq.push_back(8'($urandom));
  endtask

  task automatic commit_model(input int nwords);
    for (int i = 0; i < nwords; i++)
      exp_mem[i] = {bq[4*i+7], bq[4*i+6], bq[4*i+5], bq[4*i+4]};
  endtask

  task automatic verify_mem(input string tag);
    foreach (exp_mem[k]) begin
      @(negedge clk);
      inst_addr = 32'(4 * k) + 32'($urandom_range(0, 3));
      #1;
      total++;
      if (inst_o !== exp_mem[k]) begin
        bad++;
        $display("FAIL %s word %0d: inst_o=%08h required=%08h", tag, k, inst_o, exp_mem[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_done(input string tag);
    total++;
    if (state_dbg !== 2'd3 || load_done_o !== 1'b1 || err_o !== 1'b0 ||
        core_rstn_o !== 1'b0 || ld_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL %s done_entry: st=%0d done=%b err=%b crst=%b rdy=%b required 3 1 0 0 0",
               tag, state_dbg, load_done_o, err_o, core_rstn_o, ld_ready_o);
    end
    @(posedge clk); #1;
    total++;
    if (core_rstn_o !== 1'b1) begin
      bad++;
      $display("FAIL %s core_release: core_rstn_o=%b required=1", tag, core_rstn_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (state_dbg !== 2'd0 || core_rstn_o !== 1'b0 || ld_ready_o !== 1'b0 ||
        load_done_o !== 1'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: st=%0d crst=%b rdy=%b done=%b err=%b required 0 0 0 0 0",
               state_dbg, core_rstn_o, ld_ready_o, load_done_o, err_o);
    end
  endtask

  task automatic test_nominal();
    bq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
           8'h13, 8'h01, 8'h20, 8'h00};
    start_pulse();
    inst_addr = 32'd4; #1;
    total++;
    if (inst_o !== NOP || ld_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL in_load_fetch: inst_o=%08h rdy=%b required %08h 1", inst_o, ld_ready_o, NOP);
    end
    stream(0, bq.size());
    check_done("nominal");
    exp_mem[0] = 32'h0010_0093;
    exp_mem[1] = 32'h0020_0113;
    verify_mem("nominal");
  endtask

  task automatic test_gapped();
    int nw = $urandom_range(2, 8);
    build_load(nw);
    start_pulse();
    for (int i = 0; i < bq.size(); i++) drive_byte(bq[i], (i == bq.size() - 1) ? 0 : 2);
    check_done("gapped");
    commit_model(nw);
    verify_mem("gapped");
  endtask

  task automatic test_len_err();
    bq = '{8'h01, 8'h10, 8'h00, 8'h00};
    start_pulse();
    stream(1, bq.size());
    total++;
    if (err_o !== 1'b1 || state_dbg !== 2'd0 || core_rstn_o !== 1'b0 ||
        load_done_o !== 1'b0 || ld_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL len_err: err=%b st=%0d crst=%b done=%b rdy=%b required 1 0 0 0 0",
               err_o, state_dbg, core_rstn_o, load_done_o, ld_ready_o);
    end
    drive_ignored(3);
    verify_mem("len_err");
  endtask

  task automatic test_zero_len();
    bq = '{8'h00, 8'h00, 8'h00, 8'h00};
    start_pulse();
    stream(0, bq.size());
    check_done("zero_len");
    drive_ignored(2);
    @(negedge clk); inst_addr = 32'(4 * DEPTH); #1;
    total++;
    if (inst_o !== NOP) begin
      bad++;
      $display("FAIL oob_fetch: inst_o=%08h required=%08h", inst_o, NOP);
    end
    @(negedge clk); inst_addr = 32'd6; #1;
    total++;
    if (inst_o !== exp_mem[1]) begin
      bad++;
      $display("FAIL unaligned_fetch: inst_o=%08h required=%08h", inst_o, exp_mem[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int nw;
    build_load(3);
    start_pulse();
    stream(0, 6);
    rstn = 1'b0; #1;
    total++;
    if (state_dbg !== 2'd0 || core_rstn_o !== 1'b0 || ld_ready_o !== 1'b0 ||
        load_done_o !== 1'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: st=%0d crst=%b rdy=%b done=%b err=%b required 0 0 0 0 0",
               state_dbg, core_rstn_o, ld_ready_o, load_done_o, err_o);
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    drive_ignored(4);
    nw = $urandom_range(3, 6);
    build_load(nw);
    start_pulse();
    stream(1, bq.size());
    check_done("reload");
    commit_model(nw);
    verify_mem("reload");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      int nw = $urandom_range(1, 6);
      build_load(nw);
      start_pulse();
      stream(r, bq.size());
      check_done("b2b");
      commit_model(nw);
      verify_mem("b2b");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gapped();
    test_len_err();
    test_zero_len();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
